// File: rtl/dq_pi_ctrl.sv
// dq_pi_ctrl: sequential d/q current PI controller.
// Each accepted sample walks IDLE -> D_P -> D_I -> Q_P -> Q_I -> OUT, one
// state per clock. A single multiplier pair and integrator adder are shared
// between the d and q axes. Gains are fixed point with 1.0 = 2^OSHIFT.
module dq_pi_ctrl #(
    parameter int OSHIFT = 12
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_en,
    input  logic signed [15:0] i_id,
    input  logic signed [15:0] i_iq,
    input  logic signed [15:0] i_id_aim,
    input  logic signed [15:0] i_iq_aim,
    input  logic        [15:0] i_kp,
    input  logic        [15:0] i_ki,
    input  logic               i_clr,
    output logic               o_busy,
    output logic               o_en,
    output logic signed [15:0] o_vd,
    output logic signed [15:0] o_vq
);

    // Product width: 17-bit signed error times 17-bit zero-extended gain.
    localparam int PW = 34;
    // Sum width: holds +/-ILIM plus a full product without overflow.
    localparam int SW = (OSHIFT + 32'sd18 > 32'sd36) ? OSHIFT + 32'sd18 : 32'sd36;

    localparam logic signed [SW-1:0] ILIM_P = SW'(64'sd32767) <<< OSHIFT;
    localparam logic signed [SW-1:0] ILIM_N = -ILIM_P;
    localparam logic signed [SW-1:0] SAT_HI = SW'(64'sd32767);
    localparam logic signed [SW-1:0] SAT_LO = SW'(-64'sd32768);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_D_P  = 3'd1,
        S_D_I  = 3'd2,
        S_Q_P  = 3'd3,
        S_Q_I  = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    // Limit an integrator value to [-ILIM, +ILIM].
    function automatic logic signed [SW-1:0] clamp_integ(input logic signed [SW-1:0] v);
        if (v > ILIM_P) begin
            return ILIM_P;
        end else if (v < ILIM_N) begin
            return ILIM_N;
        end else begin
            return v;
        end
    endfunction

    // Saturate a wide signed value to the 16-bit signed range.
    function automatic logic signed [15:0] sat16(input logic signed [SW-1:0] v);
        if (v > SAT_HI) begin
            return 16'sh7fff;
        end else if (v < SAT_LO) begin
            return -16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic signed [16:0]      ed_r;
    logic signed [16:0]      eq_r;
    logic        [15:0]      kp_r;
    logic        [15:0]      ki_r;
    logic signed [PW-1:0]    pd_r;
    logic signed [PW-1:0]    pq_r;
    logic signed [SW-1:0]    integ_d_r;
    logic signed [SW-1:0]    integ_q_r;
    logic signed [15:0]      vd_r;
    logic signed [15:0]      vq_r;

    logic signed [16:0]      err_s;
    logic signed [PW-1:0]    p_sel_s;
    logic signed [SW-1:0]    integ_old_s;
    logic signed [PW-1:0]    pmul_s;
    logic signed [PW-1:0]    imul_s;
    logic signed [SW-1:0]    integ_sum_s;
    logic signed [SW-1:0]    integ_new_s;
    logic signed [SW-1:0]    vsum_s;
    logic signed [SW-1:0]    vsh_s;
    logic signed [15:0]      vsat_s;

    // Next-state sequencing: leave IDLE only on i_en, then one state per clock.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (i_en) begin
                    state_nxt_s = S_D_P;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_D_P:   state_nxt_s = S_D_I;
            S_D_I:   state_nxt_s = S_Q_P;
            S_Q_P:   state_nxt_s = S_Q_I;
            S_Q_I:   state_nxt_s = S_OUT;
            S_OUT:   state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Shared datapath: pick the active axis, multiply, integrate, clamp, shift, saturate.
    always_comb begin
        err_s       = ed_r;
        p_sel_s     = pd_r;
        integ_old_s = integ_d_r;
        if ((state_r == S_Q_P) || (state_r == S_Q_I)) begin
            err_s       = eq_r;
            p_sel_s     = pq_r;
            integ_old_s = integ_q_r;
        end else begin
            err_s       = ed_r;
            p_sel_s     = pd_r;
            integ_old_s = integ_d_r;
        end
        pmul_s      = $signed({18'd0, kp_r}) * $signed({{17{err_s[16]}}, err_s});
        imul_s      = $signed({18'd0, ki_r}) * $signed({{17{err_s[16]}}, err_s});
        integ_sum_s = integ_old_s + {{(SW-PW){imul_s[PW-1]}}, imul_s};
        integ_new_s = clamp_integ(integ_sum_s);
        vsum_s      = {{(SW-PW){p_sel_s[PW-1]}}, p_sel_s} + integ_new_s;
        vsh_s       = vsum_s >>> OSHIFT;
        vsat_s      = sat16(vsh_s);
    end

    // State, operand latches, per-axis results, integrators and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= S_IDLE;
            ed_r      <= 17'sd0;
            eq_r      <= 17'sd0;
            kp_r      <= 16'd0;
            ki_r      <= 16'd0;
            pd_r      <= {PW{1'b0}};
            pq_r      <= {PW{1'b0}};
            integ_d_r <= {SW{1'b0}};
            integ_q_r <= {SW{1'b0}};
            vd_r      <= 16'sd0;
            vq_r      <= 16'sd0;
            o_busy    <= 1'b0;
            o_en      <= 1'b0;
            o_vd      <= 16'sd0;
            o_vq      <= 16'sd0;
        end else begin
            state_r <= state_nxt_s;
            o_busy  <= (state_nxt_s != S_IDLE);
            o_en    <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (i_en) begin
                        ed_r <= $signed({i_id_aim[15], i_id_aim}) - $signed({i_id[15], i_id});
                        eq_r <= $signed({i_iq_aim[15], i_iq_aim}) - $signed({i_iq[15], i_iq});
                        kp_r <= i_kp;
                        ki_r <= i_ki;
                    end
                end
                S_D_P: pd_r <= pmul_s;
                S_D_I: begin
                    integ_d_r <= integ_new_s;
                    vd_r      <= vsat_s;
                end
                S_Q_P: pq_r <= pmul_s;
                S_Q_I: begin
                    integ_q_r <= integ_new_s;
                    vq_r      <= vsat_s;
                end
                S_OUT: begin
                    o_vd <= vd_r;
                    o_vq <= vq_r;
                    o_en <= 1'b1;
                end
                default: begin
                end
            endcase
            // Clear wins over any integrator update on the same edge.
            if (i_clr) begin
                integ_d_r <= {SW{1'b0}};
                integ_q_r <= {SW{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_dq_pi_ctrl.sv
// Bench for dq_pi_ctrl: a driver issues samples and pushes expected results
// from an arithmetic PI model into a queue; a monitor on the falling edge
// pops and compares whenever o_en is seen, and checks busy/hold every cycle.
module tb_dq_pi_ctrl;

    localparam int     OSH  = 12;
    localparam longint ILIM = 64'sd32767 * (64'sd1 <<< OSH);

    logic               clk;
    logic               rstn;
    logic               i_en;
    logic signed [15:0] i_id;
    logic signed [15:0] i_iq;
    logic signed [15:0] i_id_aim;
    logic signed [15:0] i_iq_aim;
    logic        [15:0] i_kp;
    logic        [15:0] i_ki;
    logic               i_clr;
    logic               o_busy;
    logic               o_en;
    logic signed [15:0] o_vd;
    logic signed [15:0] o_vq;

    dq_pi_ctrl #(.OSHIFT(OSH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_en     (i_en),
        .i_id     (i_id),
        .i_iq     (i_iq),
        .i_id_aim (i_id_aim),
        .i_iq_aim (i_iq_aim),
        .i_kp     (i_kp),
        .i_ki     (i_ki),
        .i_clr    (i_clr),
        .o_busy   (o_busy),
        .o_en     (o_en),
        .o_vd     (o_vd),
        .o_vq     (o_vq)
    );

    typedef struct {
        int cyc;
        int vd;
        int vq;
    } exp_t;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc      = 0;
    int     last_acc = -100;
    longint m_integ_d = 0;
    longint m_integ_q = 0;
    int     m_vd     = 0;
    int     m_vq     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic longint clampm(input longint v);
        if (v > ILIM) return ILIM;
        if (v < -ILIM) return -ILIM;
        return v;
    endfunction

    function automatic int sat16m(input longint v);
        if (v > 64'sd32767) return 32767;
        if (v < -64'sd32768) return -32768;
        return int'(v);
    endfunction

    // Reference PI step for one axis; floor division by 2^OSH.
    function automatic int pi_step(input longint e, input longint kp, input longint ki,
                                   inout longint integ);
        longint p;
        p     = kp * e;
        integ = clampm(integ + ki * e);
        return sat16m((p + integ) >>> OSH);
    endfunction

    // Drive one i_en pulse; the model decides whether the DUT is free to take it.
    task automatic send(input logic signed [15:0] ida, input logic signed [15:0] idm,
                        input logic signed [15:0] iqa, input logic signed [15:0] iqm,
                        input logic [15:0] kp, input logic [15:0] ki);
        exp_t e;
        int   acc_edge;
        @(negedge clk);
        i_id_aim = ida;
        i_id     = idm;
        i_iq_aim = iqa;
        i_iq     = iqm;
        i_kp     = kp;
        i_ki     = ki;
        i_en     = 1'b1;
        acc_edge = cyc + 1;
        if (acc_edge >= last_acc + 6) begin
            last_acc = acc_edge;
            e.cyc = acc_edge + 5;
            e.vd  = pi_step(longint'(ida) - longint'(idm), longint'(kp), longint'(ki), m_integ_d);
            e.vq  = pi_step(longint'(iqa) - longint'(iqm), longint'(kp), longint'(ki), m_integ_q);
            exp_q.push_back(e);
        end
        @(negedge clk);
        i_en = 1'b0;
    endtask

    task automatic idle_wait();
        repeat (7) @(negedge clk);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_integ_d = 0;
        m_integ_q = 0;
        m_vd      = 0;
        m_vq      = 0;
        last_acc  = -100;
    endtask

    // Monitor: score o_en events, output hold and busy against the model.
    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            check("o_busy", longint'(o_busy),
                  longint'((cyc >= last_acc) && (cyc <= last_acc + 4)));
            if (o_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_o_en", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("o_en_cycle", cyc, e.cyc);
                    check("o_vd", longint'(o_vd), e.vd);
                    check("o_vq", longint'(o_vq), e.vq);
                    m_vd = e.vd;
                    m_vq = e.vq;
                end
            end else begin
                check("hold_vd", longint'(o_vd), m_vd);
                check("hold_vq", longint'(o_vq), m_vq);
            end
        end
    end

    initial begin
        rstn = 1'b0; i_en = 1'b0; i_clr = 1'b0;
        i_id = 16'sd0; i_iq = 16'sd0; i_id_aim = 16'sd0; i_iq_aim = 16'sd0;
        i_kp = 16'd0; i_ki = 16'd0;

        // Reset held with random inputs: outputs stay zero.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            i_en = 1'($urandom); i_clr = 1'($urandom);
            i_id = 16'($urandom); i_iq = 16'($urandom);
            i_id_aim = 16'($urandom); i_iq_aim = 16'($urandom);
            i_kp = 16'($urandom); i_ki = 16'($urandom);
            check("rst_o_en", longint'(o_en), 0);
            check("rst_o_busy", longint'(o_busy), 0);
            check("rst_o_vd", longint'(o_vd), 0);
            check("rst_o_vq", longint'(o_vq), 0);
        end
        @(negedge clk);
        i_en = 1'b0; i_clr = 1'b0;
        rstn = 1'b1;
        model_reset();
        idle_wait();

        // First sample after reset: integrators start from zero.
        send(16'sd50, 16'sd0, -16'sd50, 16'sd0, 16'd0, 16'd4096);
        idle_wait();
        @(negedge clk); i_clr = 1'b1; m_integ_d = 0; m_integ_q = 0;
        @(negedge clk); i_clr = 1'b0;

        // P-only operation.
        send(16'sd1000, 16'sd0, -16'sd500, 16'sd0, 16'd4096, 16'd0);
        idle_wait();

        // Integral accumulation, then clear.
        for (int k = 0; k < 3; k++) begin
            send(16'sd100, 16'sd0, -16'sd100, 16'sd0, 16'd0, 16'd4096);
            idle_wait();
        end
        @(negedge clk); i_clr = 1'b1; m_integ_d = 0; m_integ_q = 0;
        @(negedge clk); i_clr = 1'b0;
        send(16'sd100, 16'sd0, -16'sd100, 16'sd0, 16'd0, 16'd4096);
        idle_wait();

        // Saturation and integrator clamp; probe with a small negative step.
        for (int k = 0; k < 11; k++) begin
            send(16'sd32767, -16'sd32768, 16'sd32767, -16'sd32768, 16'd65535, 16'd65535);
            idle_wait();
        end
        send(16'sd0, 16'sd1, 16'sd0, 16'sd1, 16'd0, 16'd4096);
        idle_wait();
        check("integ_d_model_at_limit", m_integ_d, ILIM - 64'sd4096);
        for (int k = 0; k < 3; k++) begin
            send(-16'sd32768, 16'sd32767, -16'sd32768, 16'sd32767, 16'd65535, 16'd65535);
            idle_wait();
        end

        // Busy drop: second pulse two cycles after an accepted one.
        send(16'sd300, 16'sd100, -16'sd300, -16'sd100, 16'd4096, 16'd0);
        send(16'sd7000, 16'sd0, 16'sd7000, 16'sd0, 16'd8192, 16'd0);
        check("busy_during_drop", longint'(o_busy), 1);
        idle_wait();

        // Reset mid-sample during Q_P: sample abandoned.
        send(16'sd2000, 16'sd0, 16'sd2000, 16'sd0, 16'd4096, 16'd4096);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        #1;
        check("midrst_o_busy", longint'(o_busy), 0);
        check("midrst_o_vd", longint'(o_vd), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("no_o_en_after_rst", longint'(o_en), 0);
        end
        send(16'sd100, 16'sd0, -16'sd100, 16'sd0, 16'd0, 16'd4096);
        idle_wait();

        // Randomized samples, with occasional dropped pulses while busy.
        for (int k = 0; k < 40; k++) begin
            logic [15:0] kp;
            logic [15:0] ki;
            kp = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 8192)) : 16'($urandom);
            ki = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 2048)) : 16'($urandom);
            send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), kp, ki);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                     16'($urandom), 16'($urandom));
            end
            repeat (7 + $urandom_range(0, 3)) @(negedge clk);
        end

        repeat (12) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
